// File: rtl/nand_result_serializer_pkg.sv
// Shared definitions for the NAND result serializer slice.
//   NAND_WIDTH : word width produced by the NAND stage (default WIDTH)
//   state_t    : serializer FSM state encoding
package nand_result_serializer_pkg;

  localparam int unsigned NAND_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/nand_result_serializer_fifo.sv
// nand_result_fifo: DEPTH x WIDTH word buffer with registered count.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   push       : write wr_data at wr_ptr (caller guarantees !full)
//   pop        : advance rd_ptr (caller guarantees !empty)
//   wr_data    : word to store
//   rd_data    : head word, combinational read
//   full/empty : decoded from the registered count
module nand_result_fifo
  import nand_result_serializer_pkg::*;
#(
  parameter int unsigned WIDTH  = NAND_WIDTH,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until a push has filled it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/nand_result_serializer.sv
// nand_result_serializer: buffers NAND result words and emits each one
// LSB first followed by an even-parity bit.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in_data/in_valid    : input word handshake; in_ready = FIFO not full
//   ser_out/ser_valid   : serial bit stream; ser_ready accepts a bit
//   ser_last            : marks the parity (frame end) bit
//   words_sent          : completed frames, wraps at 256
module nand_result_serializer
  import nand_result_serializer_pkg::*;
#(
  parameter int unsigned WIDTH  = NAND_WIDTH,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready,
  output logic [7:0]       words_sent
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shreg;
  logic             parity;
  logic [CNT_W-1:0] bitcnt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  nand_result_fifo #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // The parity-bit handshake reloads directly so back-to-back frames
  // have no idle cycle between them.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ready && (bitcnt == LAST_BIT)) next_state = PARITY;
      end
      PARITY: begin
        if (ser_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = SHIFT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      parity     <= 1'b0;
      bitcnt     <= '0;
      words_sent <= '0;
    end else begin
      if (pop) begin
        shreg  <= head;
        parity <= ^head;
        bitcnt <= '0;
      end else if ((state == SHIFT) && ser_ready) begin
        shreg  <= shreg >> 1;
        bitcnt <= bitcnt + 1'b1;
      end
      if ((state == PARITY) && ser_ready) words_sent <= words_sent + 1'b1;
    end
  end

  always_comb begin
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    case (state)
      SHIFT: begin
        ser_out   = shreg[0];
        ser_valid = 1'b1;
      end
      PARITY: begin
        ser_out   = parity;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nand_result_serializer.sv
// Self-checking bench for nand_result_serializer: table of single-word
// frames plus directed backpressure, FIFO-full, back-to-back and
// mid-frame reset sequences. Expected frames are hand-computed as
// {parity, word} with bit i being the i-th serial bit.
module tb_nand_result_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_last;
  logic       ser_ready;
  logic [7:0] words_sent;

  int checks = 0;
  int errors = 0;
  int sent_exp = 0;

  typedef struct {
    logic [7:0] data;
    logic [8:0] frame;
  } vec_t;

  vec_t vecs [6];

  nand_result_serializer #(
    .WIDTH  (8),
    .DEPTH  (4),
    .ADDR_W (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .ser_ready  (ser_ready),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe and accept bits [s, e) of a frame; ser_ready must be 1.
  task automatic recv_bits(input logic [8:0] f, input int s, input int e, input string name);
    for (int b = s; b < e; b++) begin
      check({name, " valid"}, 32'(ser_valid), 32'd1);
      check({name, " bit"}, 32'(ser_out), 32'(f[b]));
      check({name, " last"}, 32'(ser_last), 32'(b == 8));
      tick();
    end
  endtask

  task automatic push_one(input logic [7:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [8:0] bb [3];
  int k, first, last_c;

  initial begin
    vecs[0] = '{8'hCF, 9'h0CF};
    vecs[1] = '{8'h01, 9'h101};
    vecs[2] = '{8'h00, 9'h000};
    vecs[3] = '{8'h80, 9'h180};
    vecs[4] = '{8'h6E, 9'h16E};
    vecs[5] = '{8'hFF, 9'h0FF};
    bb[0] = 9'h03C;
    bb[1] = 9'h107;
    bb[2] = 9'h180;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; ser_ready = 1'b0;
    tick(); tick();
    check("rst ser_out", 32'(ser_out), 0);
    check("rst ser_valid", 32'(ser_valid), 0);
    check("rst ser_last", 32'(ser_last), 0);
    check("rst words_sent", 32'(words_sent), 0);
    check("rst in_ready", 32'(in_ready), 1);
    reset = 1'b0;
    tick();

    // Single-word frames
    ser_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_one(vecs[i].data);
      check("push-edge idle", 32'(ser_valid), 0);
      tick();
      recv_bits(vecs[i].frame, 0, 9, "vec");
      sent_exp++;
      check("vec words_sent", 32'(words_sent), 32'(sent_exp));
      check("vec idle after", 32'(ser_valid), 0);
    end

    // Backpressure after bit 3
    push_one(8'hCF);
    tick();
    recv_bits(9'h0CF, 0, 3, "bp pre");
    ser_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp hold bit", 32'(ser_out), 32'(1'b1));
      check("bp hold valid", 32'(ser_valid), 1);
      check("bp hold last", 32'(ser_last), 0);
    end
    ser_ready = 1'b1;
    recv_bits(9'h0CF, 3, 9, "bp post");
    sent_exp++;
    check("bp words_sent", 32'(words_sent), 32'(sent_exp));

    // FIFO full: first word sits in the shift register, four more fill the FIFO
    ser_ready = 1'b0;
    push_one(8'hA5);
    push_one(8'h5A);
    push_one(8'hFF);
    push_one(8'h00);
    check("full 4 in_ready", 32'(in_ready), 1);
    push_one(8'h3C);
    check("full 5 in_ready", 32'(in_ready), 0);
    in_data = 8'h07; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("full blocked", 32'(in_ready), 0);
      check("full hold bit", 32'(ser_out), 1);
    end
    ser_ready = 1'b1;
    recv_bits(9'h0A5, 0, 9, "full A5");
    check("full reopen", 32'(in_ready), 1);
    recv_bits(9'h05A, 0, 1, "full 5A");
    in_valid = 1'b0;
    check("full refill", 32'(in_ready), 0);
    recv_bits(9'h05A, 1, 9, "full 5A");
    recv_bits(9'h0FF, 0, 9, "full FF");
    recv_bits(9'h000, 0, 9, "full 00");
    recv_bits(9'h03C, 0, 9, "full 3C");
    recv_bits(9'h107, 0, 9, "full 07");
    sent_exp += 6;
    check("full words_sent", 32'(words_sent), 32'(sent_exp));
    check("full idle", 32'(ser_valid), 0);

    // Back-to-back frames
    k = 0; first = -1; last_c = -1;
    in_data = 8'h3C; in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 0) in_data = 8'h07;
      else if (c == 1) in_data = 8'h80;
      else if (c == 2) in_valid = 1'b0;
      if (ser_valid) begin
        if (k < 27) begin
          check("b2b bit", 32'(ser_out), 32'(bb[k / 9][k % 9]));
          check("b2b last", 32'(ser_last), 32'((k % 9) == 8));
        end
        k++;
        if (first < 0) first = c;
        last_c = c;
      end
    end
    sent_exp += 3;
    check("b2b valid count", 32'(k), 27);
    check("b2b first", 32'(first), 1);
    check("b2b contiguous", 32'(last_c - first + 1), 27);
    check("b2b words_sent", 32'(words_sent), 32'(sent_exp));

    // Reset during bit 4 with two words queued
    in_valid = 1'b1;
    in_data = 8'hCF; tick();
    in_data = 8'h01; tick();
    in_data = 8'h00; tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid bit4", 32'(ser_out), 0);
    check("mid valid", 32'(ser_valid), 1);
    reset = 1'b1;
    #1;
    check("arst ser_valid", 32'(ser_valid), 0);
    check("arst ser_out", 32'(ser_out), 0);
    check("arst ser_last", 32'(ser_last), 0);
    check("arst in_ready", 32'(in_ready), 1);
    check("arst words_sent", 32'(words_sent), 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post-rst idle", 32'(ser_valid), 0);
    end
    check("post-rst words", 32'(words_sent), 0);
    push_one(8'h01);
    tick();
    recv_bits(9'h101, 0, 9, "post-rst 01");
    check("post-rst words 1", 32'(words_sent), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
